// File: rtl/shift_mult_pkg.sv
// shift_mult_pkg: shared widths and FSM state type for the shift multiplier datapath
package shift_mult_pkg;
    localparam int WIDTH = 11;
    localparam int PWIDTH = 2 * WIDTH;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential shift-and-add magnitude multiplier with sign apply
module shift_add_multiplier
    import shift_mult_pkg::*;
#(
    parameter int WIDTH = shift_mult_pkg::WIDTH,
    parameter int PWIDTH = 2 * WIDTH
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [WIDTH-1:0]  a_mag,
    input  logic [WIDTH-1:0]  b_mag,
    input  logic              a_sign,
    input  logic              b_sign,
    output logic              busy,
    output logic              done,
    output logic [PWIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH);
    state_t            state;
    logic [PWIDTH-1:0] mcand;
    logic [PWIDTH-1:0] acc;
    logic [PWIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0]  mplier;
    logic [CW-1:0]     cnt;
    logic              neg;
    // accumulator value including this cycle's partial product
    always_comb acc_nxt = mplier[0] ? acc + mcand : acc;
    // FSM and datapath; product is negated on the way out when the signs differ
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            mcand   <= '0;
            acc     <= '0;
            mplier  <= '0;
            cnt     <= '0;
            neg     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    mcand  <= PWIDTH'(a_mag);
                    mplier <= b_mag;
                    neg    <= a_sign ^ b_sign;
                    acc    <= '0;
                    cnt    <= '0;
                    busy   <= 1'b1;
                    state  <= RUN;
                end
                RUN: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        product <= neg ? ~acc_nxt + PWIDTH'(1) : acc_nxt;
                        state   <= DONE;
                    end
                end
                default: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb_shift_add_multiplier: directed vectors with hand-computed products
module tb_shift_add_multiplier;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [10:0] a_mag = '0;
    logic [10:0] b_mag = '0;
    logic        a_sign = 1'b0;
    logic        b_sign = 1'b0;
    logic        busy;
    logic        done;
    logic [21:0] product;
    int          n_vec = 0;
    int          n_err = 0;

    shift_add_multiplier dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a_mag(a_mag), .b_mag(b_mag), .a_sign(a_sign), .b_sign(b_sign),
        .busy(busy), .done(done), .product(product)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [10:0] a, input logic as_, input logic [10:0] b, input logic bs);
        a_mag = a; a_sign = as_; b_mag = b; b_sign = bs;
    endtask

    // waits (bounded) at negedges until done; returns busy-cycle count
    task automatic wait_done(output int lat);
        lat = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (busy) lat++;
            @(negedge clk);
        end
    endtask

    task automatic mult(input string tag, input logic [10:0] a, input logic as_,
                        input logic [10:0] b, input logic bs, input logic [21:0] exp);
        int lat;
        @(negedge clk);
        drive(a, as_, b, bs);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drive(~a, ~as_, ~b, ~bs);
        wait_done(lat);
        check({tag, " latency"}, lat, 11);
        check({tag, " done"}, done, 1);
        check({tag, " busy@done"}, busy, 0);
        check({tag, " product"}, product, exp);
        @(negedge clk);
        check({tag, " done drop"}, done, 0);
        check({tag, " held"}, product, exp);
    endtask

    initial begin
        int lat;
        int per;
        repeat (2) @(negedge clk);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst product", product, 0);
        rst_n = 1'b1;

        mult("5x3", 11'd5, 0, 11'd3, 0, 22'd15);
        mult("-7x6", 11'd7, 1, 11'd6, 0, 22'h3FFFD6);
        mult("-7x-6", 11'd7, 1, 11'd6, 1, 22'h00002A);
        mult("-1024x-1024", 11'h400, 1, 11'h400, 1, 22'h100000);
        mult("1023x-1023", 11'd1023, 0, 11'd1023, 1, 22'h3007FF);
        mult("-0x5", 11'd0, 1, 11'd5, 0, 22'd0);

        // start held high: back-to-back operations every 13 cycles
        @(negedge clk);
        drive(11'd5, 0, 11'd3, 0);
        start = 1'b1;
        wait_done(lat);
        check("b2b first product", product, 15);
        @(negedge clk);
        per = 1;
        for (int i = 0; i < 40 && !done; i++) begin
            per++;
            @(negedge clk);
        end
        check("b2b period", per, 13);
        check("b2b second product", product, 15);
        start = 1'b0;
        repeat (14) @(negedge clk);

        // start pulses during RUN and DONE ignored
        drive(11'd7, 0, 11'd6, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        drive(11'd1, 1, 11'd1, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        check("ign run product", product, 42);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("ign done busy", busy, 0);
        @(negedge clk);
        check("ign done stays idle", busy, 0);
        check("ign done product", product, 42);

        // reset mid-RUN discards the operation
        drive(11'd9, 0, 11'd9, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst busy", busy, 0);
        check("midrst done", done, 0);
        check("midrst product", product, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post rst idle", busy, 0);
        mult("post rst 12x-10", 11'd12, 0, 11'd10, 1, 22'h3FFF88);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
